spi_master: RTL

Single-clock SPI master that drives the slave's `MOSI`/`SS_n` and samples its `MISO`. It converts one 10-bit command word into a complete slave frame and, for read-data frames, captures the 8-bit reply. It sits between the test/host logic and the SPI slave + RAM wrapper, and shares `clk` with the slave. No separate SCK is generated: the slave samples on `clk`.

---
 rtl/spi_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: turns one command word into a complete slave frame and, for
// read-data frames, collects the slave's reply byte from MISO. The slave
// shares clk, so the master only drives MOSI/SS_n and samples MISO.
//
// END is the closing cycle of a frame. It is the last cycle with SS_n low
// and carries command bit 0 on MOSI (or MISO reply bit 0 on a read-data
// frame). SS_n release, done, rd_valid and the rd_data update all register
// on the edge that leaves END. The single SS_n-high cycle that follows is
// therefore already IDLE with cmd_ready high, and the next word can be
// accepted 13 edges after the previous one.
module spi_master #(
  parameter int ADDR_SIZE = 8,
  parameter int RD_LAT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_SIZE+1:0] cmd_data,
  input  logic                 MISO,
  output logic                 MOSI,
  output logic                 SS_n,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done
);

  localparam int W    = ADDR_SIZE + 2;
  localparam int CMAX = (W > RD_LAT) ? W : RD_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_CMD, ST_SHIFT, ST_WAIT, ST_RECV, ST_END
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-2:0]           sh_q, sh_d;        // bits still to go out after MOSI
  logic [ADDR_SIZE-2:0]   rx_q, rx_d;        // reply bits gathered in RECV
  logic                   rd_frame_q, rd_frame_d;
  logic                   mosi_q, mosi_d;
  logic                   ss_n_q, ss_n_d;
  logic [ADDR_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign MOSI      = mosi_q;
  assign SS_n      = ss_n_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rd_frame_d = rd_frame_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        cnt_d  = '0;
        if (cmd_valid && cmd_ready) begin
          sh_d       = cmd_data[W-2:0];
          mosi_d     = cmd_data[W-1];
          ss_n_d     = 1'b0;
          rd_frame_d = &cmd_data[W-1:W-2];
          state_d    = ST_SEL;
        end
      end
      ST_SEL: state_d = ST_CMD;
      ST_CMD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == CW'(W - 1)) begin
          // Only read-data frames get here: bit 0 has just been captured.
          mosi_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          mosi_d = sh_q[W-2];
          sh_d   = {sh_q[W-3:0], 1'b0};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 2) && !rd_frame_q) begin
            state_d = ST_END;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(RD_LAT - 2)) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RECV: begin
        rx_d = {rx_q[ADDR_SIZE-3:0], MISO};
        if (cnt_q == CW'(ADDR_SIZE - 2)) begin
          state_d = ST_END;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (rd_frame_q) begin
          rd_data_d  = {rx_q, MISO};
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset abandons a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_frame_q <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_frame_q <= rd_frame_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

endmodule
